// File: rtl/bus_arb_pkg.sv
// Shared widths, FSM state type and one-hot helper for the 8-way bus arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned HOLD_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_8_rr_pick.sv
// Round-robin winner search: first set candidate scanning upward from i_ptr,
// wrapping 7 -> 0.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_cand,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_win,
  output logic               o_found
);

  logic [SEL_W-1:0] w_idx;
  logic             w_hit;

  always_comb begin
    w_idx   = '0;
    w_hit   = 1'b0;
    o_win   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_idx = i_ptr + SEL_W'(i);
      if (!w_hit && i_cand[w_idx]) begin
        o_win = w_idx;
        w_hit = 1'b1;
      end
    end
    o_found = w_hit;
  end

endmodule

// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter for the shared 16-bit bus mux: registered one-hot grant,
// mux select, and forced rotation of a contested owner after MAX_HOLD cycles.
module bus_arbiter_8
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NUM_REQ-1:0] Req,
  output logic [NUM_REQ-1:0] Gnt,
  output logic [SEL_W-1:0]   Sel,
  output logic               BusValid,
  output logic               Preempt
);

  arb_state_t         r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0]   r_owner, w_owner_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_preempt, w_preempt_nxt;

  logic [NUM_REQ-1:0] w_owner_mask;
  logic [NUM_REQ-1:0] w_cand;
  logic               w_owner_req;
  logic [SEL_W-1:0]   w_win;
  logic               w_found;
  logic               w_grant;

  // While owned, the owner is never its own successor: either it released
  // (its bit is already 0) or it is being preempted (must be masked).
  assign w_owner_mask = onehot8(r_owner);
  assign w_owner_req  = |(Req & w_owner_mask);
  assign w_cand       = (r_state == OWNED) ? (Req & ~w_owner_mask) : Req;

  rr_pick u_rr_pick (
    .i_cand  (w_cand),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_found (w_found)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_hold    <= '0;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_hold    <= w_hold_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_valid   <= w_valid_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_hold_nxt    = r_hold;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_valid_nxt   = r_valid;
    w_preempt_nxt = 1'b0;
    w_grant       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_found) w_grant = 1'b1;
      end
      OWNED: begin
        if (!w_owner_req) begin
          if (w_found) begin
            w_grant = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
          end
        end else if (r_hold < HOLD_W'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end else if (w_found) begin
          w_grant       = 1'b1;
          w_preempt_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase

    // Any new grant: load owner, restart hold count, demote the winner.
    if (w_grant) begin
      w_state_nxt = OWNED;
      w_gnt_nxt   = onehot8(w_win);
      w_sel_nxt   = w_win;
      w_owner_nxt = w_win;
      w_hold_nxt  = HOLD_W'(1);
      w_ptr_nxt   = w_win + SEL_W'(1);
      w_valid_nxt = 1'b1;
    end
  end

  assign Gnt      = r_gnt;
  assign Sel      = r_sel;
  assign BusValid = r_valid;
  assign Preempt  = r_preempt;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed bench for bus_arbiter_8: expected outputs are queued as each step is
// driven and checked one clock later against the default and MAX_HOLD=4 instances.
module tb_bus_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b;
  logic       valid_a, valid_b, pre_a, pre_b;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       pre;
    bit         use_b;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  bus_arbiter_8 dut_a (
    .Clk(clk), .Rst_n(rst_n), .Req(req_a),
    .Gnt(gnt_a), .Sel(sel_a), .BusValid(valid_a), .Preempt(pre_a)
  );

  bus_arbiter_8 #(.MAX_HOLD(4)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Req(req_b),
    .Gnt(gnt_b), .Sel(sel_b), .BusValid(valid_b), .Preempt(pre_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive requests, queue the expected post-edge outputs, then check them.
  task automatic step(input logic [7:0] ra, input logic [7:0] rb, input bit use_b,
                      input logic [7:0] eg, input logic [2:0] es, input logic ev,
                      input logic ep, input string tag);
    exp_t e;
    req_a = ra;
    req_b = rb;
    e.gnt = eg; e.sel = es; e.valid = ev; e.pre = ep; e.use_b = use_b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.use_b) begin
      chk({tag, ".gnt"},   gnt_b,         e.gnt);
      chk({tag, ".sel"},   8'(sel_b),     8'(e.sel));
      chk({tag, ".valid"}, 8'(valid_b),   8'(e.valid));
      chk({tag, ".pre"},   8'(pre_b),     8'(e.pre));
    end else begin
      chk({tag, ".gnt"},   gnt_a,         e.gnt);
      chk({tag, ".sel"},   8'(sel_a),     8'(e.sel));
      chk({tag, ".valid"}, 8'(valid_a),   8'(e.valid));
      chk({tag, ".pre"},   8'(pre_a),     8'(e.pre));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    @(posedge clk);
    #1;
    chk("rst.gnt",   gnt_a,       8'h00);
    chk("rst.sel",   8'(sel_a),   8'h00);
    chk("rst.valid", 8'(valid_a), 8'h00);
    chk("rst.pre",   8'(pre_a),   8'h00);
    rst_n = 1'b1;

    // Reset and single request
    step(8'h00, 8'h00, 0, 8'h00, 3'd0, 1'b0, 1'b0, "idle");
    step(8'h20, 8'h00, 0, 8'h20, 3'd5, 1'b1, 1'b0, "single5");
    step(8'h00, 8'h00, 0, 8'h00, 3'd5, 1'b0, 1'b0, "release_keep_sel");

    // Round-robin fairness between requesters 0 and 4 (ptr starts at 6)
    step(8'h11, 8'h00, 0, 8'h01, 3'd0, 1'b1, 1'b0, "rr0_a");
    chk("rr.ptr_after_grant0", 8'(dut_a.r_ptr), 8'd1);
    step(8'h11, 8'h00, 0, 8'h01, 3'd0, 1'b1, 1'b0, "rr0_b");
    step(8'h10, 8'h00, 0, 8'h10, 3'd4, 1'b1, 1'b0, "rr4_a");
    step(8'h11, 8'h00, 0, 8'h10, 3'd4, 1'b1, 1'b0, "rr4_b");
    step(8'h01, 8'h00, 0, 8'h01, 3'd0, 1'b1, 1'b0, "rr0_c");
    step(8'h11, 8'h00, 0, 8'h01, 3'd0, 1'b1, 1'b0, "rr0_d");
    step(8'h10, 8'h00, 0, 8'h10, 3'd4, 1'b1, 1'b0, "rr4_c");
    step(8'h00, 8'h00, 0, 8'h00, 3'd4, 1'b0, 1'b0, "rr_idle");

    // Zero-bubble handover 2 -> 6
    step(8'h04, 8'h00, 0, 8'h04, 3'd2, 1'b1, 1'b0, "own2");
    step(8'h44, 8'h00, 0, 8'h04, 3'd2, 1'b1, 1'b0, "own2_hold");
    step(8'h40, 8'h00, 0, 8'h40, 3'd6, 1'b1, 1'b0, "handover6");
    step(8'h00, 8'h00, 0, 8'h00, 3'd6, 1'b0, 1'b0, "handover_idle");

    // Uncontested saturation of requester 7 for 20 cycles
    for (int k = 0; k < 20; k++)
      step(8'h80, 8'h00, 0, 8'h80, 3'd7, 1'b1, 1'b0, $sformatf("sat%0d", k));
    chk("sat.hold", dut_a.r_hold, 8'd8);

    // A new requester at saturation forces preemption immediately
    step(8'h81, 8'h00, 0, 8'h01, 3'd0, 1'b1, 1'b1, "sat_preempt");
    step(8'h81, 8'h00, 0, 8'h01, 3'd0, 1'b1, 1'b0, "sat_after");

    // Asynchronous reset mid-grant
    step(8'h08, 8'h00, 0, 8'h08, 3'd3, 1'b1, 1'b0, "own3");
    #2 rst_n = 1'b0;
    #1;
    chk("async.gnt",   gnt_a,       8'h00);
    chk("async.sel",   8'(sel_a),   8'h00);
    chk("async.valid", 8'(valid_a), 8'h00);
    chk("async.ptr",   8'(dut_a.r_ptr), 8'h00);
    #1 rst_n = 1'b1;
    step(8'hFF, 8'h00, 0, 8'h01, 3'd0, 1'b1, 1'b0, "post_rst_all");
    step(8'h00, 8'h00, 0, 8'h00, 3'd0, 1'b0, 1'b0, "post_rst_idle");

    // Preemption with MAX_HOLD=4, requesters 0 and 1 held continuously
    for (int c = 0; c < 17; c++) begin
      logic       own1;
      logic [7:0] eg;
      own1 = ((c / 4) % 2) == 1;
      eg   = own1 ? 8'h02 : 8'h01;
      step(8'h00, 8'h03, 1, eg, own1 ? 3'd1 : 3'd0, 1'b1,
           (c > 0) && (c % 4 == 0), $sformatf("pre%0d", c));
    end
    step(8'h00, 8'h00, 1, 8'h00, 3'd0, 1'b0, 1'b0, "pre_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_8.md
# bus_arbiter_8

Round-robin arbiter that shares the processor's 16-bit 8-input bus mux among eight requesters. It samples eight request lines and issues a registered one-hot grant. It drives the mux's 3-bit select so that the granted requester's 16-bit word appears on the shared bus. A contested owner is forcibly rotated out after a bounded hold time, so no requester can starve the others.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles an owner keeps the bus while another requester waits. Legal range 1..255.
- `Clk`  in  1  rising-edge clock.
- `Rst_n`  in  1  reset, asynchronous assert, active-low. One clock domain; reset is asynchronous and active-low.
- `Req`  in  8  request lines. `Req[i]` is held high for as long as requester i wants the bus.
- `Gnt`  out  8  registered one-hot grant, or all zeros.
- `Sel`  out  3  registered bus-mux select; equals the index of the set `Gnt` bit.
- `BusValid`  out  1  registered; 1 when and only when `Gnt` is nonzero.
- `Preempt`  out  1  registered one-cycle pulse on the cycle a grant moves because of hold expiry.

## Operation
- **State:** FSM {IDLE, OWNED}, 3-bit round-robin pointer `Ptr`, 3-bit `Owner`, 8-bit `HoldCnt`.
- **Reset values:** state IDLE, `Gnt`=0, `Sel`=0, `BusValid`=0, `Preempt`=0, `Ptr`=0, `HoldCnt`=0.
- **Winner search:**
  - Scan upward from `Ptr` and wrap 7→0; the first asserted candidate wins.
  - Candidates are `Req`, except during preemption, where `Owner` is masked out.
- **IDLE:**
  - If `Req`≠0, go to OWNED with `Gnt`=onehot(win), `Sel`=win, `Owner`=win, `HoldCnt`=1, `Ptr`=win+1 (mod 8).
  - Otherwise stay in IDLE.
- **OWNED, `Req[Owner]`=0 (release):**
  - If other requests are pending, regrant directly to the new winner with no idle bubble, `HoldCnt`=1.
  - If none are pending, go to IDLE with `Gnt`=0 and `BusValid`=0. `Sel` keeps its last value.
- **OWNED, `Req[Owner]`=1:**
  - `HoldCnt`<`MAX_HOLD`: keep the grant and increment `HoldCnt`.
  - `HoldCnt`=`MAX_HOLD` with another request pending: preempt, regrant to the masked winner, `Preempt`=1 for one cycle, `HoldCnt`=1.
  - `HoldCnt`=`MAX_HOLD` with no other request pending: keep the grant; `HoldCnt` saturates at `MAX_HOLD`.
- **Pointer:** `Ptr` updates only on a new grant, to winner+1, so the most recently served requester has the lowest priority next time.
- **Invariants:** `Gnt` is never multi-hot. `Sel` and `Gnt` always change on the same edge.

## Timing
- `Req` sampled at edge k → `Gnt`, `Sel`, `BusValid` valid after edge k+1. Arbitration latency is 1 cycle.
- Owner drops `Req` before edge k → new owner's grant appears after edge k. Handover has zero dead cycles.
- Under contention, an owner holds the bus for at most `MAX_HOLD` cycles. With all 8 requesting, worst-case wait is 7×`MAX_HOLD`+1 cycles.
- A requester that drops `Req` in the same cycle it would be granted loses nothing; it is simply not a candidate.
- `Rst_n` low mid-ownership: all outputs clear immediately (asynchronous), without waiting for a clock edge. The first grant after reset release starts the search at index 0.
- `MAX_HOLD`=1: a contested owner rotates every cycle.

## Structure
- Package `bus_arb_pkg` holds:
  - `NUM_REQ`=8 and `SEL_W`=3.
  - the `arb_state_t` enum {IDLE, OWNED}.
  - an `onehot8(idx)` function.
- One combinational sub-module, `rr_pick`:
  - inputs: 8-bit candidate vector, 3-bit `Ptr`.
  - outputs: 3-bit winner index and a `found` flag.
- Top level: FSM, `Ptr`/`Owner`/`HoldCnt` registers, output registers.

## Test plan
- **Reset and single request:** release `Rst_n`, `Req`=8'h00 → `Gnt`=0, `BusValid`=0. Then `Req`=8'h20 → one cycle later `Gnt`=8'h20, `Sel`=5.
- **Round-robin fairness:** `Req`=8'h11 with each owner releasing after 2 cycles and re-requesting → grants alternate 0, 4, 0, 4; `Ptr` after the first grant is 1.
- **Preemption:** `MAX_HOLD`=4, `Req`=8'h03 held high continuously → owner 0 for 4 cycles, `Preempt` pulses, then owner 1 for 4 cycles, and so on.
- **Zero-bubble handover:** owner 2 drops `Req` while `Req[6]`=1 → `Gnt` goes 8'h04→8'h40 on one edge; `BusValid` stays 1.
- **Uncontested saturation:** single requester 7 held for 20 cycles with `MAX_HOLD`=8 → `Gnt` stays 8'h80, `HoldCnt`=8, `Preempt` never asserts.
- **Asynchronous reset mid-grant:** pulse `Rst_n` low between edges while `Gnt`=8'h08 → outputs clear immediately; next grant with `Req`=8'hFF goes to index 0.
